// File: rtl/elastic_pipe_chain.sv
// elastic_pipe_chain: DEPTH-stage valid/ready register chain carrying a
// WIDTH-bit payload, with bubble collapsing and per-stage flush.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     producer handshake, in_data payload in
//   out_valid/out_ready   consumer handshake, out_data from last stage
//   flush, flush_mask     kill entries landing in masked stages
//   stage_valid           registered per-stage valid bits
//   occupancy             registered count of valid stages
module elastic_pipe_chain #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    input  logic [DEPTH-1:0]           flush_mask,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [OW-1:0]    r_occ;

    logic [DEPTH:0]   w_acc;
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_src_d [DEPTH];
    logic [DEPTH-1:0] w_nv;
    logic [OW-1:0]    w_cnt;

    // A stage can take new data if it is empty or everything
    // downstream of it moves; a running variable keeps the
    // ripple out of a self-referencing vector.
    always_comb begin
        logic a;
        a = out_ready;
        w_acc = '0;
        w_acc[DEPTH] = a;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            a = ~r_v[k] | a;
            w_acc[k] = a;
        end
    end

    always_comb begin
        w_src_v = '0;
        w_src_v[0] = in_valid;
        w_src_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            w_src_v[k] = r_v[k-1];
            w_src_d[k] = r_d[k-1];
        end
    end

    // Flush masks the next valid state only; the entry leaving
    // the last stage this cycle has already been handed off.
    always_comb begin
        w_nv  = '0;
        w_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_nv[k] = (w_acc[k] ? w_src_v[k] : r_v[k])
                    & ~(flush & flush_mask[k]);
            w_cnt = w_cnt + OW'(w_nv[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_occ <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= '0;
            end
        end else begin
            r_v   <= w_nv;
            r_occ <= w_cnt;
            for (int k = 0; k < DEPTH; k++) begin
                if (w_acc[k] && w_src_v[k]) begin
                    r_d[k] <= w_src_d[k];
                end
            end
        end
    end

    assign in_ready    = rst_n & w_acc[0];
    assign out_valid   = r_v[DEPTH-1];
    assign out_data    = r_d[DEPTH-1];
    assign stage_valid = r_v;
    assign occupancy   = r_occ;

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// tb_elastic_pipe_chain: directed stimulus with a queue scoreboard;
// a negedge monitor compares every delivered entry in order.
module tb_elastic_pipe_chain;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [DEPTH-1:0] flush_mask;
    logic [DEPTH-1:0] stage_valid;
    logic [2:0]       occupancy;

    int errs   = 0;
    int checks = 0;
    logic [WIDTH-1:0] exp_q [$];

    elastic_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush       (flush),
        .flush_mask  (flush_mask),
        .stage_valid (stage_valid),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_out: got %0h expected none",
                         out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < max_cyc) begin
            cyc();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        out_ready = 1'b0;
    endtask

    task automatic fill4();
        out_ready = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            cyc();
            in_valid = 1'b1;
            in_data  = 64'(j);
        end
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 64'hAA;
        out_ready  = 1'b0;
        flush      = 1'b0;
        flush_mask = '0;

        // reset
        repeat (3) begin
            cyc();
            @(negedge clk);
            chk("rst in_ready", in_ready, 0);
            chk("rst out_valid", out_valid, 0);
            chk("rst stage_valid", stage_valid, 0);
            chk("rst occupancy", occupancy, 0);
        end
        cyc();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("rel in_ready", in_ready, 1);

        // streaming, latency DEPTH
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            in_valid = 1'b1;
            in_data  = 64'(i + 1);
            exp_q.push_back(64'(i + 1));
            @(negedge clk);
            chk("t2 in_ready", in_ready, 1);
            chk("t2 out_valid", out_valid, (i >= 4) ? 64'd1 : 64'd0);
        end
        cyc();
        in_valid = 1'b0;
        drain(20);

        // fill under backpressure
        cyc();
        in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data = 64'h11 + 64'(j);
            @(negedge clk);
            chk("t3 in_ready", in_ready, 1);
            cyc();
        end
        in_data = 64'h15;
        @(negedge clk);
        chk("t3 full in_ready", in_ready, 0);
        chk("t3 occupancy", occupancy, 4);
        chk("t3 stage_valid", stage_valid, 4'hF);
        chk("t3 out_data", out_data, 64'h11);
        cyc();
        @(negedge clk);
        chk("t3 hold in_ready", in_ready, 0);
        chk("t3 hold out_data", out_data, 64'h11);
        cyc();
        for (int j = 0; j < 5; j++) exp_q.push_back(64'h11 + 64'(j));
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3 pass in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        drain(20);

        // bubble collapse
        cyc();
        in_valid = 1'b1;
        in_data  = 64'hA0;
        cyc();
        in_valid = 1'b0;
        cyc();
        in_valid = 1'b1;
        in_data  = 64'hB0;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        chk("t4 stage_valid", stage_valid, 4'b1100);
        chk("t4 occupancy", occupancy, 2);
        chk("t4 out_data", out_data, 64'hA0);
        exp_q.push_back(64'hA0);
        exp_q.push_back(64'hB0);
        drain(10);

        // flush, stalled
        fill4();
        flush      = 1'b1;
        flush_mask = 4'b0011;
        cyc();
        flush      = 1'b0;
        flush_mask = '0;
        @(negedge clk);
        chk("t5a stage_valid", stage_valid, 4'b1100);
        chk("t5a occupancy", occupancy, 2);
        chk("t5a out_data", out_data, 64'd1);
        exp_q.push_back(64'd1);
        exp_q.push_back(64'd2);
        drain(10);

        // flush while moving
        fill4();
        flush      = 1'b1;
        flush_mask = 4'b0011;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = 64'd5;
        exp_q.push_back(64'd1);
        @(negedge clk);
        chk("t5b in_ready", in_ready, 1);
        cyc();
        flush      = 1'b0;
        flush_mask = '0;
        out_ready  = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        chk("t5b stage_valid", stage_valid, 4'b1100);
        chk("t5b occupancy", occupancy, 2);
        chk("t5b out_data", out_data, 64'd2);
        chk("t5b delivered", 64'(exp_q.size()), 64'd0);
        exp_q.push_back(64'd2);
        exp_q.push_back(64'd3);
        drain(10);

        // reset mid-operation
        fill4();
        exp_q.delete();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h99;
        @(negedge clk);
        chk("t6 rst in_ready", in_ready, 0);
        cyc();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6 stage_valid", stage_valid, 0);
        chk("t6 occupancy", occupancy, 0);
        chk("t6 out_valid", out_valid, 0);
        chk("t6 out_data", out_data, 0);
        repeat (3) cyc();
        @(negedge clk);
        chk("t6 still empty", stage_valid, 0);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
